// File: rtl/rtc_mux_display_if.sv
// Bundle between the RTC core and its board-side controls and display pins.
// slave: the clock core (controls in, display/time out); master: the driver.
`timescale 1ns/1ps
interface rtc_mux_display_if;
    logic       mode_12h;
    logic       disp_sel;
    logic       set_en;
    logic       inc_hr;
    logic       inc_min;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       led;
    logic       pm;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;

    modport slave (
        input  mode_12h, disp_sel, set_en, inc_hr, inc_min,
        output seg, dp, an, led, pm, hours, minutes, seconds
    );

    modport master (
        output mode_12h, disp_sel, set_en, inc_hr, inc_min,
        input  seg, dp, an, led, pm, hours, minutes, seconds
    );
endinterface

// File: rtl/rtc_mux_display.sv
// 24h/12h settable real-time clock with HH:MM / MM:SS view, 4-digit mux scan.
// Ports: clk, rst_n (sync, active low); bus.slave carries mode_12h, disp_sel,
// set_en, inc_hr, inc_min in and seg, dp, an, led, pm, hours, minutes,
// seconds out. All logic runs in the clk domain using tick enables.
`timescale 1ns/1ps
module rtc_mux_display #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    rtc_mux_display_if.slave   bus
);

    localparam int DIV = CLK_HZ / (4 * REFRESH_HZ);
    localparam int PW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [PW-1:0] pre_q;
    logic          tick;
    logic [4:0]    hr_q, hr_n;
    logic [5:0]    min_q, min_n;
    logic [5:0]    sec_q, sec_n;
    logic          led_q, led_n;
    logic          pm_q;

    logic [SW-1:0] scan_q;
    logic [1:0]    idx_q;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    // Prescaler is parked at zero in set mode so the first tick after
    // leaving set mode comes a full second later.
    assign tick = !bus.set_en && (pre_q == PRE_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (bus.set_en || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    always_comb begin
        hr_n  = hr_q;
        min_n = min_q;
        sec_n = sec_q;
        led_n = led_q;
        unique case (1'b1)
            bus.set_en: begin
                sec_n = 6'd0;
                // Minute setting wraps without touching hours.
                if (bus.inc_min)
                    min_n = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (bus.inc_hr)
                    hr_n = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end
            tick: begin
                led_n = ~led_q;
                if (sec_q == 6'd59) begin
                    sec_n = 6'd0;
                    if (min_q == 6'd59) begin
                        min_n = 6'd0;
                        hr_n  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                    end else begin
                        min_n = min_q + 6'd1;
                    end
                end else begin
                    sec_n = sec_q + 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hr_q  <= '0;
            min_q <= '0;
            sec_q <= '0;
            led_q <= 1'b0;
            pm_q  <= 1'b0;
        end else begin
            hr_q  <= hr_n;
            min_q <= min_n;
            sec_q <= sec_n;
            led_q <= led_n;
            pm_q  <= (hr_n >= 5'd12);
        end
    end

    logic [4:0] hr_12;
    logic [5:0] hv;
    logic [3:0] d3, d2, d1, d0, dig;
    logic       blank3, blank;
    logic [6:0] seg_lit;
    logic [3:0] onehot;

    always_comb begin
        if (hr_q == 5'd0)
            hr_12 = 5'd12;
        else if (hr_q > 5'd12)
            hr_12 = hr_q - 5'd12;
        else
            hr_12 = hr_q;
        hv = {1'b0, bus.mode_12h ? hr_12 : hr_q};
    end

    always_comb begin
        d3     = tens(hv);
        d2     = units(hv);
        d1     = tens(min_q);
        d0     = units(min_q);
        blank3 = 1'b0;
        if (bus.disp_sel) begin
            d3 = tens(min_q);
            d2 = units(min_q);
            d1 = tens(sec_q);
            d0 = units(sec_q);
        end else begin
            // Leading hour zero is suppressed only in 12h format.
            blank3 = bus.mode_12h && (d3 == 4'd0);
        end
    end

    always_comb begin
        dig   = d0;
        blank = 1'b0;
        unique case (idx_q)
            2'd0: dig = d0;
            2'd1: dig = d1;
            2'd2: dig = d2;
            2'd3: begin
                dig   = d3;
                blank = blank3;
            end
        endcase
        seg_lit = blank ? 7'h00 : seg7(dig);
        seg_d   = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        onehot  = 4'b0001 << idx_q;
        an_d    = AN_ACTIVE_LOW ? ~onehot : onehot;
        // Colon blinks with the seconds LED on the hour-units digit.
        dp_d    = ((idx_q == 2'd2) && led_q) ^ SEG_ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q <= '0;
            idx_q  <= 2'd0;
            seg_q  <= SEG_OFF;
            dp_q   <= DP_OFF;
            an_q   <= AN_OFF;
        end else begin
            if (scan_q == SCAN_MAX) begin
                scan_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                scan_q <= scan_q + SW'(1);
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.an      = an_q;
    assign bus.led     = led_q;
    assign bus.pm      = pm_q;
    assign bus.hours   = hr_q;
    assign bus.minutes = min_q;
    assign bus.seconds = sec_q;

endmodule
